alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer for the shared `alu` datapath. It accepts one operation at a time from either of two requester ports, using round-robin priority. It drives a single internal `alu` instance from registered operands and returns the registered result on the owning requester's response port. It sits between the instruction-execute logic (requester 0) and the address/auxiliary logic (requester 1), which would otherwise each need their own ALU.

## Interface
- `WORD_SIZE`, 16, operand and result width; passed to the internal `alu`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has an operation pending.
- `req0_ready`  out  1  arbiter accepts requester 0's operation this cycle.
- `req0_op`  in  4  opcode: ADD=0, SUB=1, LEFT_SHIFT=2, RIGHT_SHIFT_ARITHMETIC=3, RIGHT_SHIFT_LOGIC=4, AND=5, OR=6, XOR=7, EQUAL=8.
- `req0_a`  in  WORD_SIZE  operand a.
- `req0_b`  in  WORD_SIZE  operand b.
- `rsp0_valid`  out  1  result for requester 0 is available.
- `rsp0_ready`  in  1  requester 0 consumes the result.
- `rsp0_data`  out  WORD_SIZE  result.
- `req1_*`, `rsp1_*`: identical set for requester 1.
- `busy`  out  1  high in EXEC or RESP.

## Operation
- FSM states:
  - IDLE (reset state).
  - EXEC.
  - RESP.
- Priority pointer `prio` (1 bit):
  - Reset value 0, which favours requester 0.
- IDLE:
  - Winner selection:
    - Only one valid: that requester wins.
    - Both valid: requester `prio` wins.
    - Neither valid: no winner.
  - Only the winner's `reqN_ready` is 1. Ready depends combinationally on the valids; the valids must not depend on ready.
  - On `valid && ready`, latch `op`, `a`, `b` and `owner`, set `prio` to the other requester, and go to EXEC.
- EXEC:
  - The `alu` evaluates the latched operands.
  - Its output is captured into the result register.
  - Next state is RESP.
- RESP:
  - `rsp<owner>_valid` is 1 and the other `rspN_valid` is 0.
  - The FSM holds until `rsp<owner>_ready` is 1, then returns to IDLE.
- All `reqN_ready` are 0 in EXEC and RESP; only one operation is ever outstanding.
- Arithmetic:
  - Results are exactly the `alu` output, truncated to WORD_SIZE; the arbiter does not reinterpret them.
  - EQUAL yields 1 or 0, zero-extended.
  - Shift amount is the full `b` operand, so an amount of WORD_SIZE or more yields 0 for left and logical shifts.
- Opcodes 9–15 are still accepted and return 0.
- `rsp0_data` and `rsp1_data` both drive the result register; it is meaningful only while the corresponding valid is high.

## Timing
- Reset values:
  - All `reqN_ready`, `rspN_valid` and `busy` are 0.
  - `rspN_data` is 0.
  - `prio` is 0 and the state is IDLE.
- Reset is asynchronous: asserting `rst_n` low forces the reset values immediately, from any state.
  - An in-flight operation is discarded, with no response.
- Latency:
  - Acceptance at edge N.
  - Cycle N→N+1 is EXEC.
  - Result registered at edge N+1; `rspN_valid` is high from edge N+1 onward.
- After the response handshake at edge M, the FSM is in IDLE during cycle M→M+1.
  - The earliest next acceptance is edge M+1.
  - Peak throughput is one operation per 3 cycles.
- While `rspN_valid` is high, `rspN_data` is stable until the handshake.
  - The register keeps its value until the next EXEC.
- Simultaneous requests alternate strictly, because `prio` toggles at every acceptance.
- A requester may drop `valid` before acceptance without effect.

## Test plan
1. **Single request.** After reset, req0 sends ADD a=0x0003, b=0x0004 with `rsp0_ready`=1.
   - Accepted at the first edge.
   - `rsp0_valid` is high one edge later with `rsp0_data`=0x0007.
   - `rsp1_valid` stays 0 throughout.
2. **Simultaneous requests from reset.**
   - Stimulus: req0 SUB 0x0005−0x0007; req1 XOR 0x00F0^0x0FF0.
   - req0 is served first with 0xFFFE.
   - req1 is accepted at the edge after the rsp0 handshake, with result 0x0F00.
3. **Continuous contention.** Both requesters hold valid for 12 cycles with ready tied high.
   - Acceptances alternate 0,1,0,1, one every 3 cycles.
4. **Backpressure.** `rsp1_ready` is held 0 for 5 cycles in RESP.
   - `rsp1_valid` stays 1 and `rsp1_data` stays stable.
   - `req0_ready` stays 0 despite `req0_valid`=1.
   - req0 is accepted the edge after `rsp1_ready` rises and completes.
5. **Operation edge cases.**
   - EQUAL 0x1234/0x1234 → 0x0001.
   - EQUAL 0x1234/0x1235 → 0x0000.
   - LEFT_SHIFT 0x0001 by 0x0010 → 0x0000.
   - AND 0xFF00&0x0FF0 → 0x0F00.
   - op=0xF → 0x0000.
6. **Reset mid-operation.** `rst_n` is pulled low in the EXEC cycle.
   - `busy`, all readys and all valids go 0 immediately.
   - No response appears.
   - After release, with both requesting, req0 wins.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one alu between two requesters.
// One operation in flight at a time: accept in IDLE, evaluate in EXEC, hold the result in RESP.

module alu #(
    parameter int WORD_SIZE = 16
) (
    input  logic [3:0]           op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic [WORD_SIZE-1:0] result
);
    always_comb begin
        result = '0;
        case (op)
            4'd0: result = a + b;
            4'd1: result = a - b;
            4'd2: result = a << b;
            4'd3: result = $signed(a) >>> b;
            4'd4: result = a >> b;
            4'd5: result = a & b;
            4'd6: result = a | b;
            4'd7: result = a ^ b;
            4'd8: result = {{(WORD_SIZE-1){1'b0}}, a == b};
            default: result = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [3:0]           req0_op,
    input  logic [WORD_SIZE-1:0] req0_a,
    input  logic [WORD_SIZE-1:0] req0_b,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [WORD_SIZE-1:0] rsp0_data,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [3:0]           req1_op,
    input  logic [WORD_SIZE-1:0] req1_a,
    input  logic [WORD_SIZE-1:0] req1_b,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [WORD_SIZE-1:0] rsp1_data,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t               state, state_nxt;
    logic                 prio;
    logic                 owner;
    logic [3:0]           op_q;
    logic [WORD_SIZE-1:0] a_q, b_q, result_q, alu_y;
    logic                 grant0, grant1;

    // prio only breaks ties; a lone requester always wins
    assign grant0 = req0_valid && (!req1_valid || !prio);
    assign grant1 = req1_valid && (!req0_valid ||  prio);

    alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) state_nxt = EXEC;
            end
            EXEC: begin
                busy      = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                busy       = 1'b1;
                rsp0_valid = !owner;
                rsp1_valid = owner;
                if (owner ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio     <= 1'b0;
            owner    <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else if (state == IDLE && (grant0 || grant1)) begin
            owner <= grant1;
            prio  <= grant0;
            op_q  <= grant1 ? req1_op : req0_op;
            a_q   <= grant1 ? req1_a  : req0_a;
            b_q   <= grant1 ? req1_b  : req0_b;
        end else if (state == EXEC) begin
            result_q <= alu_y;
        end
    end

    assign rsp0_data = result_q;
    assign rsp1_data = result_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboarded bench for alu_arbiter: directed scenarios followed by random traffic.
module tb_alu_arbiter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_op = '0, req1_op = '0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [W-1:0] rsp0_data, rsp1_data;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int m_phase = 0;
    bit m_prio = 1'b0;
    bit m_owner = 1'b0;
    bit rnd_run = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.WORD_SIZE(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from the opcode definitions, using plain integer math
    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int ua, ub, sa, p;
        logic [W-1:0] r;
        ua = a;
        ub = b;
        sa = $signed(a);
        r  = '0;
        case (op)
            4'd0: r = W'(ua + ub);
            4'd1: r = W'(ua - ub);
            4'd2: r = (ub >= W) ? '0 : W'(ua * (1 << ub));
            4'd3: begin
                if (ub >= W) r = (sa < 0) ? '1 : '0;
                else begin
                    p = 1 << ub;
                    r = (sa >= 0) ? W'(sa / p) : W'(-((-sa + p - 1) / p));
                end
            end
            4'd4: r = (ub >= W) ? '0 : W'(ua / (1 << ub));
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8: r = (a == b) ? W'(1) : W'(0);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Monitor: transaction-level model of one outstanding op with a toggling tie-break
    always @(negedge clk) begin
        logic er0, er1, ev0, ev1;
        if (!rst_n) begin
            m_phase = 0;
            m_prio  = 1'b0;
        end else begin
            er0 = (m_phase == 0) && req0_valid && (!req1_valid || !m_prio);
            er1 = (m_phase == 0) && req1_valid && (!req0_valid ||  m_prio);
            ev0 = (m_phase == 2) && !m_owner;
            ev1 = (m_phase == 2) &&  m_owner;
            chk("req0_ready", W'(req0_ready), W'(er0));
            chk("req1_ready", W'(req1_ready), W'(er1));
            chk("rsp0_valid", W'(rsp0_valid), W'(ev0));
            chk("rsp1_valid", W'(rsp1_valid), W'(ev1));
            chk("busy", W'(busy), W'(m_phase != 0));
            if (ev0) begin
                if (q0.size() == 0) chk("rsp0_unexpected", W'(1), W'(0));
                else begin
                    chk("rsp0_data", rsp0_data, q0[0]);
                    if (rsp0_ready) void'(q0.pop_front());
                end
            end
            if (ev1) begin
                if (q1.size() == 0) chk("rsp1_unexpected", W'(1), W'(0));
                else begin
                    chk("rsp1_data", rsp1_data, q1[0]);
                    if (rsp1_ready) void'(q1.pop_front());
                end
            end
            case (m_phase)
                0: if (req0_valid || req1_valid) begin
                    m_owner = (req0_valid && req1_valid) ? m_prio : req1_valid;
                    m_prio  = !m_owner;
                    m_phase = 1;
                end
                1: m_phase = 2;
                default: if (m_owner ? rsp1_ready : rsp0_ready) m_phase = 0;
            endcase
        end
    end

    task automatic send(input int n, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        int t;
        logic rdy;
        t = 0;
        if (n == 0) begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
            q0.push_back(ref_alu(op, a, b));
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
            q1.push_back(ref_alu(op, a, b));
        end
        do begin
            @(negedge clk);
            t++;
            rdy = (n == 0) ? req0_ready : req1_ready;
        end while (!rdy && t < 60 && rst_n);
        if (!rdy) chk($sformatf("accept_timeout%0d", n), W'(0), W'(1));
        @(posedge clk);
        #1;
        if (n == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("drain_timeout", W'(q0.size() + q1.size()), W'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_rsp0_data", rsp0_data, W'(0));
        chk("reset_ready", W'({req0_ready, req1_ready, rsp0_valid, rsp1_valid}), W'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request, then simultaneous requests
        rsp0_ready = 1'b1;
        send(0, 4'd0, 16'h0003, 16'h0004);
        drain();
        fork
            send(0, 4'd1, 16'h0005, 16'h0007);
            send(1, 4'd7, 16'h00F0, 16'h0FF0);
        join
        drain();

        // Continuous contention
        fork
            repeat (2) send(0, 4'd6, 16'h1200, 16'h0034);
            repeat (2) send(1, 4'd5, 16'hF0F0, 16'h0FF0);
        join
        drain();

        // Backpressure on requester 1 while requester 0 waits
        rsp1_ready = 1'b0;
        rsp0_ready = 1'b1;
        send(1, 4'd0, 16'h1111, 16'h2222);
        fork
            send(0, 4'd1, 16'h0100, 16'h0001);
            begin
                @(posedge clk);
                repeat (5) @(posedge clk);
                #1;
                rsp1_ready = 1'b1;
            end
        join
        drain();

        // Operation edge cases
        send(0, 4'd8, 16'h1234, 16'h1234);
        send(0, 4'd8, 16'h1234, 16'h1235);
        send(0, 4'd2, 16'h0001, 16'h0010);
        send(0, 4'd5, 16'hFF00, 16'h0FF0);
        send(0, 4'hF, 16'hABCD, 16'h1234);
        send(0, 4'd3, 16'h8000, 16'h0020);
        drain();

        // Reset during EXEC
        send(0, 4'd0, 16'h0001, 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_outs", W'({req0_ready, req1_ready, rsp0_valid, rsp1_valid}), W'(0));
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fork
            send(0, 4'd0, 16'h0010, 16'h0020);
            send(1, 4'd0, 16'h0030, 16'h0040);
        join
        drain();

        // Random traffic with random response backpressure
        rnd_run = 1'b1;
        fork
            while (rnd_run) begin
                @(posedge clk);
                #1;
                rsp0_ready = 1'($urandom_range(0, 1));
                rsp1_ready = 1'($urandom_range(0, 1));
            end
        join_none
        fork
            for (int i = 0; i < 25; i++) begin
                send(0, 4'($urandom_range(0, 15)), W'($urandom),
                     ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 18)));
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            for (int j = 0; j < 25; j++) begin
                send(1, 4'($urandom_range(0, 15)), W'($urandom),
                     ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 18)));
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        join
        rnd_run = 1'b0;
        @(posedge clk);
        #2;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
